ot_fifo64: RTL and testbench

Output-side buffer that sits directly downstream of the per-row 64-bit output multiplexer. It receives the multiplexer's one-beat-per-cycle `valid`/`data` stream, which has no backpressure, and stores it in a power-of-two FIFO. It presents the data on a valid/ready master port toward the DMA/output stream and tags frame boundaries with `m_last`. It flags near-full early enough for the quant/PE scheduler to stall, and records any beat lost to overflow.

---
 rtl/ot_pkg.sv | 13 +
 rtl/ot_fifo_mem.sv | 32 +++
 rtl/ot_fifo64.sv | 102 ++++++++++
 tb/tb_ot_fifo64.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ot_pkg : shared sizing for the output-side bitmux and FIFO.   Rev 1.0
// ---------------------------------------------------------------------------
package ot_pkg;

  localparam int TBITS           = 64;
  localparam int OT_FIFO_DEPTH   = 16;
  localparam int OT_AFULL_MARGIN = 8;
  localparam int OT_LEN_W        = 16;

endpackage
`default_nettype wire

// File: rtl/ot_fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ot_fifo_mem : DEPTH x TBITS register file, sync write, async read.   Rev 1.0
// ---------------------------------------------------------------------------
module ot_fifo_mem
  import ot_pkg::*;
#(
  parameter int TBITS  = ot_pkg::TBITS,
  parameter int DEPTH  = OT_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TBITS-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [TBITS-1:0]  rd_data
);

  logic [TBITS-1:0] mem [DEPTH];

  // Storage is intentionally not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/ot_fifo64.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ot_fifo64 : FWFT output FIFO with frame-last tagging and sticky overflow.
// Rev 1.0
// ---------------------------------------------------------------------------
module ot_fifo64
  import ot_pkg::*;
#(
  parameter int TBITS        = ot_pkg::TBITS,
  parameter int DEPTH        = OT_FIFO_DEPTH,
  parameter int AFULL_MARGIN = OT_AFULL_MARGIN,
  parameter int LEN_W        = OT_LEN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_din,
  input  logic [TBITS-1:0]        data_din,
  input  logic [LEN_W-1:0]        frame_len,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [TBITS-1:0]        m_data,
  output logic                    m_last,
  output logic                    almost_full,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] AFULL_LEVEL = CNT_W'(DEPTH - AFULL_MARGIN);

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] last_idx;
  logic             push;
  logic             pop;

  // Flags come from registered pointers only, so acceptance never depends on m_ready.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full = (count >= AFULL_LEVEL);

  assign m_valid = !empty;
  assign push    = valid_din && !full;
  assign pop     = m_valid && m_ready;

  // A zero frame length behaves as a one-beat frame.
  assign last_idx = (frame_len == '0) ? '0 : frame_len - 1'b1;
  assign m_last   = m_valid && (beat_cnt == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (valid_din && full) begin
      overflow <= 1'b1;
    end
  end

  ot_fifo_mem #(
    .TBITS  (TBITS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_din),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (m_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ot_fifo64.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ot_fifo64 : table vectors, directed corner cases and random traffic
// against a queue-based reference model.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_ot_fifo64;

  logic        clk;
  logic        reset;
  logic        valid_din;
  logic [63:0] data_din;
  logic [15:0] frame_len;
  logic        m_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic        almost_full;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;

  ot_fifo64 dut (
    .clk         (clk),
    .reset       (reset),
    .valid_din   (valid_din),
    .data_din    (data_din),
    .frame_len   (frame_len),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .almost_full (almost_full),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Reference model: queue of stored beats, pops-in-frame counter, sticky drop.
  logic [63:0] mq[$];
  bit          m_ovf;
  int          k;
  int          n_pops;
  bit          pop_was_last;

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          r;
    int          e_cnt;
    bit          e_mv;
    bit          e_af;
    bit          e_full;
    bit          e_ovf;
    bit          chk_d;
    logic [63:0] e_d;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int flen_eff();
    return (frame_len == 16'd0) ? 1 : int'(frame_len);
  endfunction

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("count", 64'(count), 64'(sz));
    chk("m_valid", 64'(m_valid), 64'(sz > 0));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == 16));
    chk("almost_full", 64'(almost_full), 64'(sz >= 8));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("m_last", 64'(m_last), 64'((sz > 0) && (k + 1 == flen_eff())));
    if (sz > 0) chk("m_data", m_data, mq[0]);
  endtask

  task automatic cycle(input bit v, input logic [63:0] d, input bit r);
    bit mfull;
    bit elast;
    valid_din = v;
    data_din  = d;
    m_ready   = r;
    pop_was_last = m_valid && m_ready && m_last;
    mfull = (mq.size() == 16);
    if (v && mfull) m_ovf = 1'b1;
    if (r && mq.size() > 0) begin
      elast = (k + 1 == flen_eff());
      void'(mq.pop_front());
      k = elast ? 0 : k + 1;
      n_pops++;
    end
    if (v && !mfull) mq.push_back(d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is raised between edges and the outputs must clear before any edge.
  task automatic do_reset();
    valid_din = 1'b0;
    m_ready   = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    mq.delete();
    m_ovf = 1'b0;
    k = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] mask6;
    logic [3:0] mask4;
    int pushed;
    int maxc;
    int cyc;
    n_vec = 0;
    n_bad = 0;
    n_pops = 0;
    reset = 1'b1;
    valid_din = 1'b0;
    data_din = '0;
    m_ready = 1'b0;
    frame_len = 16'd1;

    // Table: single push/pop, fill through almost_full to full, then a dropped push.
    tbl[0] = '{1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001};
    tbl[1] = '{1'b0, 64'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    for (int i = 0; i < 16; i++)
      tbl[2+i] = '{1'b1, 64'h100 + 64'(i), 1'b0, i + 1, 1'b1, (i + 1) >= 8, (i + 1) == 16,
                   1'b0, 1'b1, 64'h100};
    tbl[18] = '{1'b1, 64'hBAD, 1'b1, 15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h101};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_count", 64'(count), 64'(tbl[i].e_cnt));
      chk("tbl_m_valid", 64'(m_valid), 64'(tbl[i].e_mv));
      chk("tbl_afull", 64'(almost_full), 64'(tbl[i].e_af));
      chk("tbl_full", 64'(full), 64'(tbl[i].e_full));
      chk("tbl_overflow", 64'(overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].chk_d) chk("tbl_m_data", m_data, tbl[i].e_d);
    end
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", m_data, 64'h100 + 64'(i));
      cycle(1'b0, 64'h0, 1'b1);
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Frame tagging, with a reset in the middle of the second frame.
    frame_len = 16'd4;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0);
    mask6 = '0;
    for (int p = 0; p < 6; p++) begin
      cycle(1'b0, 64'h0, 1'b1);
      mask6[p] = pop_was_last;
    end
    chk("last_mask_pre", 64'(mask6), 64'h08);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h300 + 64'(i), 1'b0);
    mask4 = '0;
    for (int p = 0; p < 4; p++) begin
      cycle(1'b0, 64'h0, 1'b1);
      mask4[p] = pop_was_last;
    end
    chk("last_mask_post", 64'(mask4), 64'h8);

    // Streaming, producer stalls on almost_full while m_ready toggles.
    frame_len = 16'd3;
    do_reset();
    pushed = 0;
    maxc = 0;
    cyc = 0;
    n_pops = 0;
    while ((pushed < 40 || mq.size() > 0) && cyc < 400) begin
      if (pushed < 40 && !almost_full) begin
        cycle(1'b1, 64'hA000 + 64'(pushed), (cyc % 2) == 0);
        pushed++;
      end else begin
        cycle(1'b0, 64'h0, (cyc % 2) == 0);
      end
      if (int'(count) > maxc) maxc = int'(count);
      cyc++;
    end
    chk("stream_done", 64'(cyc < 400), 64'd1);
    chk("stream_pops", 64'(n_pops), 64'd40);
    chk("stream_no_drop", 64'(overflow), 64'd0);
    chk("stream_max_count", 64'(maxc <= 16), 64'd1);

    // Random traffic: slow consumer forces overflow, then a faster one.
    frame_len = 16'd0;
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) == 0);
    frame_len = 16'd5;
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(($urandom % 2) != 0, {$urandom, $urandom}, ($urandom % 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
